instruction_fetcher: RTL and testbench
======================================

# instruction_fetcher

Fetch stage that turns the predictor's `pc` into instructions for the instruction queue/decoder. It sits directly downstream of `branch_target_buffer`: it reads `pc_out`, `stop_fetching`, and `roll_back`, and drives the `fetch_new_instruction` pulse back to it. Instructions come from a direct-mapped word-granular instruction cache, refilled through a request/done handshake with the memory controller.

## Interface
- `ICACHE_LINES`, default 32: number of one-word cache lines; must be a power of two ≥2. IDX = log2(ICACHE_LINES).
- `clk_in`  in  1  system clock; all state changes on its rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  ready; when low, all state and outputs freeze and inputs are ignored.
- `pc_in`  in  32  next fetch address (predictor `pc_out`).
- `stop_fetching`  in  1  high: start no new fetch (JALR pending).
- `roll_back`  in  1  mispredict flush; `pc_in` is already corrected in the same cycle.
- `iq_full`  in  1  instruction queue cannot accept an instruction.
- `mc_req`  out  1  memory read request, held until done.
- `mc_addr`  out  32  word address of the request (bits [1:0] = 0).
- `mc_done`  in  1  one-cycle pulse: `mc_data` valid.
- `mc_data`  in  32  fetched little-endian instruction word.
- `inst_valid`  out  1  one-cycle pulse; drives predictor `fetch_new_instruction` and the queue push.
- `inst_out`  out  32  instruction word, valid with `inst_valid`.
- `inst_pc`  out  32  address of `inst_out`.

## Operation
- Address split: index = `pc_in`[IDX+1:2]; tag = `pc_in`[31:IDX+2]. Each line holds valid, tag, and data.
- The FSM has four states:
  - **IDLE**: if `roll_back`, `stop_fetching`, or `iq_full` is high, stay in IDLE. Otherwise look up `pc_in`.
    - Hit: register `inst_valid`=1, `inst_out`=data, `inst_pc`=`pc_in`; go to WAIT_PC.
    - Miss: register `mc_req`=1 and `mc_addr`={`pc_in`[31:2],2'b00}; go to WAIT_MEM.
  - **WAIT_PC**: one-cycle bubble while the predictor advances `pc` on the pulse. `inst_valid` returns to 0. Next state is IDLE.
  - **WAIT_MEM**: on `mc_done`, write the line (valid=1, tag, data), drop `mc_req`, and go to IDLE. The next cycle hits.
  - **DRAIN**: wait for `mc_done`, fill the line, drop `mc_req`, and go to IDLE. Never emit the word.
- Roll-back handling:
  - In IDLE or WAIT_PC: go to IDLE and clear `inst_valid`.
  - In WAIT_MEM: go to DRAIN, because an in-flight memory read is never aborted.
  - If `mc_done` and `roll_back` arrive in the same cycle in WAIT_MEM: perform the fill, go to IDLE, emit nothing.
- `stop_fetching` is checked only in IDLE. A refill already issued completes normally.
- `iq_full` is checked only in IDLE, at lookup time. An emitted pulse is never retracted.
- Lines are never invalidated after reset; instruction memory is read-only.
- On reset:
  - state = IDLE; all valid bits = 0.
  - `mc_req`=0, `mc_addr`=0, `inst_valid`=0, `inst_out`=0, `inst_pc`=0.
  - Reset asserted mid-refill abandons the transaction. The memory controller is reset by the same signal.

## Timing
- Hit: lookup in cycle t → `inst_valid` high in cycle t+1 for exactly one cycle → WAIT_PC in t+1 → next lookup in t+2. Maximum throughput is one instruction per 2 cycles.
- Miss: `mc_req` rises in t+1 and stays high through the `mc_done` cycle d. It is low from d+1. Lookup in d+1 hits, so `inst_valid` is high at d+2.
- `mc_addr` is stable for the whole time `mc_req` is high.
- `inst_out` and `inst_pc` hold their last values while `inst_valid` is 0.
- `rdy_in` low for N cycles stretches every latency by N. A pulse registered before the freeze stays high for the frozen cycles.

## Configuration
- `ICACHE_EN` defined: the cache is built as described above.
- `ICACHE_EN` undefined: no cache storage exists and every lookup misses.
  - WAIT_MEM on `mc_done` registers `inst_valid`=1 with `inst_out`=`mc_data` and `inst_pc`=`mc_addr`, then goes to WAIT_PC.
  - DRAIN behaviour is unchanged.
  - Miss-to-pulse latency becomes d+1.

## Test plan
- **Cold miss then hit:** reset, `pc_in`=0x0, `mc_done` 5 cycles after `mc_req` with data 0x00000013 → `mc_req` high for 5 cycles with `mc_addr`=0x0; `inst_valid` pulses once with `inst_out`=0x00000013, `inst_pc`=0x0. Re-fetching 0x0 later hits with no `mc_req`.
- **Conflict eviction** (`ICACHE_LINES`=32): fetch 0x0, then 0x80 (same index, tag differs) → second fetch misses. Re-fetching 0x0 misses again.
- **Roll-back during refill:** `roll_back` at cycle 2 of a miss to 0x10 → DRAIN; `mc_done` fills the line; no `inst_valid`. Next lookup at `pc_in`=0x40 misses with `mc_addr`=0x40.
- **Stall inputs:** `iq_full`=1 or `stop_fetching`=1 held for 4 cycles in IDLE → no `mc_req`, no `inst_valid`. Lookup occurs in the first cycle both are low.
- **Back-to-back hits:** warm lines 0x0 and 0x4; predictor advances `pc` on each pulse → `inst_valid` high on alternate cycles; `inst_pc` sequence 0x0, 0x4.
- **Freeze and reset:** `rdy_in`=0 for 3 cycles during WAIT_MEM → `mc_req`/`mc_addr` unchanged and `mc_done` ignored. `rst_in`=0 mid-refill → `mc_req`=0 immediately (asynchronous) and all valid bits cleared.

Source files
------------

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: fetch stage between the branch predictor and the
// instruction queue. It looks up pc_in in a direct-mapped, one-word-per-line
// instruction cache and refills misses through a req/done handshake with the
// memory controller.
// Build option: define ICACHE_EN to build the cache. With ICACHE_EN undefined,
// there is no cache storage, every lookup misses, and the refilled word is
// emitted directly from the memory response.
module instruction_fetcher #(
    parameter int ICACHE_LINES = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] pc_in,
    input  logic        stop_fetching,
    input  logic        roll_back,
    input  logic        iq_full,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PC  = 2'd1,
        ST_WAIT_MEM = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        mc_req_r;
    logic        mc_req_s;
    logic [31:0] mc_addr_r;
    logic [31:0] mc_addr_s;
    logic        inst_valid_r;
    logic        inst_valid_s;
    logic [31:0] inst_out_r;
    logic [31:0] inst_out_s;
    logic [31:0] inst_pc_r;
    logic [31:0] inst_pc_s;
    logic        fill_s;
    logic        hit_s;
    logic [31:0] hit_data_s;

`ifdef ICACHE_EN
    localparam int IDX   = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX;

    logic [ICACHE_LINES-1:0] line_vld_r;
    logic [TAG_W-1:0]        line_tag_r  [ICACHE_LINES];
    logic [31:0]             line_data_r [ICACHE_LINES];
    logic [IDX-1:0]          rd_idx_s;
    logic [IDX-1:0]          wr_idx_s;

    // Lookup uses the incoming pc; refills write the line of the outstanding request.
    assign rd_idx_s = pc_in[IDX+1:2];
    assign wr_idx_s = mc_addr_r[IDX+1:2];

    // Hit detection and read data for the current pc.
    always_comb begin
        hit_s      = line_vld_r[rd_idx_s] && (line_tag_r[rd_idx_s] == pc_in[31:IDX+2]);
        hit_data_s = line_data_r[rd_idx_s];
    end

    // Valid bits: cleared only by reset, set by each refill (memory is read-only).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            line_vld_r <= {ICACHE_LINES{1'b0}};
        end else if (rdy_in && fill_s) begin
            line_vld_r[wr_idx_s] <= 1'b1;
        end
    end

    // Tag and data storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_s) begin
            line_tag_r[wr_idx_s]  <= mc_addr_r[31:IDX+2];
            line_data_r[wr_idx_s] <= mc_data;
        end
    end
`else
    localparam int unused_lines = ICACHE_LINES;
    logic unused_s;

    // No storage: every lookup misses and refills are not retained.
    assign hit_s      = 1'b0;
    assign hit_data_s = 32'd0;
    assign unused_s   = ^{fill_s, pc_in[1:0]};
`endif

    // Next-state and next-output logic; inst_valid is a single-cycle pulse.
    always_comb begin
        state_s      = state_r;
        mc_req_s     = mc_req_r;
        mc_addr_s    = mc_addr_r;
        inst_valid_s = 1'b0;
        inst_out_s   = inst_out_r;
        inst_pc_s    = inst_pc_r;
        fill_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (roll_back || stop_fetching || iq_full) begin
                    state_s = ST_IDLE;
                end else if (hit_s) begin
                    inst_valid_s = 1'b1;
                    inst_out_s   = hit_data_s;
                    inst_pc_s    = pc_in;
                    state_s      = ST_WAIT_PC;
                end else begin
                    mc_req_s  = 1'b1;
                    mc_addr_s = {pc_in[31:2], 2'b00};
                    state_s   = ST_WAIT_MEM;
                end
            end
            ST_WAIT_PC: begin
                state_s = ST_IDLE;
            end
            ST_WAIT_MEM: begin
                if (mc_done) begin
                    fill_s   = 1'b1;
                    mc_req_s = 1'b0;
                    if (roll_back) begin
                        state_s = ST_IDLE;
                    end else begin
`ifdef ICACHE_EN
                        state_s = ST_IDLE;
`else
                        inst_valid_s = 1'b1;
                        inst_out_s   = mc_data;
                        inst_pc_s    = mc_addr_r;
                        state_s      = ST_WAIT_PC;
`endif
                    end
                end else if (roll_back) begin
                    // The memory read cannot be aborted; finish it silently.
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_WAIT_MEM;
                end
            end
            ST_DRAIN: begin
                if (mc_done) begin
                    fill_s   = 1'b1;
                    mc_req_s = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                mc_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers; everything freezes while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r      <= ST_IDLE;
            mc_req_r     <= 1'b0;
            mc_addr_r    <= 32'd0;
            inst_valid_r <= 1'b0;
            inst_out_r   <= 32'd0;
            inst_pc_r    <= 32'd0;
        end else if (rdy_in) begin
            state_r      <= state_s;
            mc_req_r     <= mc_req_s;
            mc_addr_r    <= mc_addr_s;
            inst_valid_r <= inst_valid_s;
            inst_out_r   <= inst_out_s;
            inst_pc_r    <= inst_pc_s;
        end
    end

    assign mc_req     = mc_req_r;
    assign mc_addr    = mc_addr_r;
    assign inst_valid = inst_valid_r;
    assign inst_out   = inst_out_r;
    assign inst_pc    = inst_pc_r;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Testbench for instruction_fetcher: randomized predictor/queue/memory
// stimulus checked every cycle against a transaction-level reference model
// (outstanding-request record plus a map from cache index to cached word
// address). Honours ICACHE_EN the same way as the design.
module tb_instruction_fetcher;

    localparam int LINES = 32;
`ifdef ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] pc_in;
    logic        stop_fetching;
    logic        roll_back;
    logic        iq_full;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done;
    logic [31:0] mc_data;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    instruction_fetcher #(.ICACHE_LINES(LINES)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .pc_in         (pc_in),
        .stop_fetching (stop_fetching),
        .roll_back     (roll_back),
        .iq_full       (iq_full),
        .mc_req        (mc_req),
        .mc_addr       (mc_addr),
        .mc_done       (mc_done),
        .mc_data       (mc_data),
        .inst_valid    (inst_valid),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int tests_run;
    int tests_failed;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Read-only instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = 32'($urandom_range(0, 127)) << 2;
        if ($urandom_range(0, 7) == 0) p = p | 32'($urandom_range(0, 3));
        return p;
    endfunction

    // Reference model: expected registered outputs plus transaction bookkeeping.
    bit          m_busy;      // a memory read is outstanding (mc_req high)
    bit          m_deliver;   // outstanding read still belongs to the current fetch
    bit          m_bubble;    // one-cycle gap after an emitted instruction
    bit          m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_out;
    logic [31:0] m_ipc;
    int unsigned wait_cnt;
    int unsigned m_delay;
    logic [31:0] line_addr [int];  // cache index -> word address held there
    logic [31:0] pc;

    task automatic model_reset();
        m_busy = 1'b0; m_deliver = 1'b0; m_bubble = 1'b0; m_valid = 1'b0;
        m_addr = 32'd0; m_out = 32'd0; m_ipc = 32'd0;
        wait_cnt = 0; m_delay = 1;
        line_addr.delete();
    endtask

    task automatic model_step(input bit rnd);
        logic [31:0] pcw;
        int          idx;
        bit          nv;
        nv  = 1'b0;
        pcw = {pc_in[31:2], 2'b00};
        idx = int'((pcw >> 2) % LINES);
        if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (m_busy) begin
            if (mc_done) begin
                if (CACHE_ON) line_addr[int'((m_addr >> 2) % LINES)] = m_addr;
                m_busy = 1'b0;
                if (m_deliver && !roll_back && !CACHE_ON) begin
                    nv = 1'b1; m_out = mem_word(m_addr); m_ipc = m_addr; m_bubble = 1'b1;
                end
            end else if (roll_back) begin
                m_deliver = 1'b0;
            end
        end else if (!(roll_back || stop_fetching || iq_full)) begin
            if (CACHE_ON && line_addr.exists(idx) && line_addr[idx] == pcw) begin
                nv = 1'b1; m_out = mem_word(pcw); m_ipc = pc_in; m_bubble = 1'b1;
            end else begin
                m_busy = 1'b1; m_deliver = 1'b1; m_addr = pcw; wait_cnt = 0;
                m_delay = rnd ? $urandom_range(1, 6) : 5;
            end
        end
        m_valid = nv;
    endtask

    task automatic check_outputs();
        check_val("mc_req",     {31'd0, mc_req},     {31'd0, m_busy});
        check_val("mc_addr",    mc_addr,             m_addr);
        check_val("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        check_val("inst_out",   inst_out,            m_out);
        check_val("inst_pc",    inst_pc,             m_ipc);
    endtask

    // Called at a falling edge: check outputs, then drive the next cycle's inputs.
    task automatic step(input bit rnd);
        check_outputs();
        rdy_in        = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
        roll_back     = rnd ? ($urandom_range(0, 11) == 0) : 1'b0;
        stop_fetching = rnd ? ($urandom_range(0, 9) == 0) : 1'b0;
        iq_full       = rnd ? ($urandom_range(0, 7) == 0) : 1'b0;
        if (m_valid && rdy_in) pc = (rnd && $urandom_range(0, 3) == 0) ? rand_pc() : pc + 32'd4;
        if (roll_back) pc = rand_pc();
        pc_in   = pc;
        mc_done = m_busy && (wait_cnt + 1 >= m_delay);
        mc_data = mc_done ? mem_word(m_addr) : $urandom;
        if (m_busy) wait_cnt++;
        if (rdy_in) model_step(rnd);
    endtask

    initial begin
        int guard;
        tests_run = 0; tests_failed = 0;
        rst_in = 1'b0; rdy_in = 1'b1; pc_in = 32'd0; stop_fetching = 1'b0;
        roll_back = 1'b0; iq_full = 1'b0; mc_done = 1'b0; mc_data = 32'd0;
        pc = 32'd0;
        model_reset();
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        step(1'b0);
        // Quiet phase: sequential fetch from 0x0, refills answered after 5 cycles.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            step(1'b0);
        end
        // Randomized phase with stalls, roll-backs, freezes and conflicts.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            step(1'b1);
        end
        // Asynchronous reset in the middle of a refill.
        guard = 0;
        do begin
            @(negedge clk_in);
            step(1'b1);
            guard++;
        end while (!m_busy && guard < 200);
        #2 rst_in = 1'b0;
        #1;
        model_reset();
        check_outputs();
        rdy_in = 1'b1; roll_back = 1'b0; stop_fetching = 1'b0; iq_full = 1'b0; mc_done = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        step(1'b1);
        // After reset every line is invalid again; the model's cache is empty.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk_in);
            step(1'b1);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
